prim_reqack_arb: RTL

//   Round-robin arbiter sharing one REQ/ACK handshake port among N requesters in one clock domain.
//   Its output port drives the SRC side of a REQ/ACK CDC synchronizer (src_req_i/src_ack_o).

---
 rtl/prim_reqack_arb.sv | 120 ++++++++++++
 1 files changed

// File: rtl/prim_reqack_arb.sv
// Round-robin arbiter that shares one REQ/ACK handshake port among N requesters.
// The winner's payload is latched and held with REQ until the shared ACK arrives.
module prim_reqack_arb #(
  parameter int unsigned N             = 4,
  parameter int unsigned DW            = 32,
  parameter bit          EnIdleAckChk  = 1'b1,
  localparam int unsigned IdxW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N-1:0]      req_i,
  input  logic [N*DW-1:0]   data_i,
  output logic [N-1:0]      ack_o,
  output logic              out_req_o,
  output logic [DW-1:0]     out_data_o,
  input  logic              out_ack_i,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              busy_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [DW-1:0]   data_q, data_d;

  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  int unsigned     cand;

  // Search ptr, ptr+1, ..., wrapping at N; first requester found wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_valid) state_d = StBusy;
      StBusy:  if (out_ack_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    ack_o     = '0;
    out_req_o = 1'b0;
    busy_o    = 1'b0;
    if (state_q == StBusy) begin
      out_req_o = 1'b1;
      busy_o    = 1'b1;
      if (out_ack_i) ack_o[gnt_idx_q] = 1'b1;
    end
  end

  assign out_data_o = data_q;
  assign gnt_idx_o  = gnt_idx_q;

  // Grant/payload capture and pointer update
  always_comb begin
    gnt_idx_d = gnt_idx_q;
    data_d    = data_q;
    ptr_d     = ptr_q;
    if (state_q == StIdle && win_valid) begin
      gnt_idx_d = win_idx;
      data_d    = data_i[win_idx*DW +: DW];
    end
    if (state_q == StBusy && out_ack_i) begin
      ptr_d = (gnt_idx_q == IdxW'(N - 1)) ? '0 : gnt_idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      data_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      data_q    <= data_d;
    end
  end

`ifndef SYNTHESIS
  ap_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ack_o));
  ap_ack_cause: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ack_o != '0) |-> (out_ack_i && busy_o));
  ap_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (busy_o && !out_ack_i) |=> ($stable(out_req_o) && $stable(out_data_o)));
  ap_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_o |-> req_i[gnt_idx_q]);
  ap_idle_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (EnIdleAckChk && out_ack_i) |-> busy_o);
`endif

endmodule
